// File: rtl/dm_access_master.sv
// dm_access_master
//   Processor-side initiator for a word-addressed 1024 x 32 data memory.
//   It takes byte, halfword and word load/store requests on byte addresses
//   through a valid/ready handshake. Sub-word stores are done as a
//   read-modify-write. Load data is sign- or zero-extended, and every request
//   ends with a one-cycle response pulse.
//
// States:
//   IDLE   | ready for a request; request fields latched on accept
//   ACCESS | memory word addressed; load extract, word store, or RMW merge
//   WRITE  | merged sub-word store written back (mem_we for one cycle)
//   RESP   | resp_valid pulse with the latched error flag
//
// Ports:
//   CLK, RESET       clock (rising edge) and asynchronous active-low reset
//   req_*            request handshake: write/size/signed/byte addr/wdata
//   resp_*           completion pulse, error flag, load data
//   mem_address/data/we, mem_q   memory port (mem_q is a combinational read)
module dm_access_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   mdata_q, mdata_d;

  logic                req_err;
  logic                word_store;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [DATA_W-1:0]   load_ext;
  logic [DATA_W-1:0]   merged;

  // Misalignment or the reserved size code; checked on the live inputs
  // because the decision is taken on the accept edge.
  assign req_err = (req_size == 2'b11) ||
                   ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  assign word_store = write_q && (size_q == SZ_WORD);

  // Little-endian lane select: byte lane addr[1:0], half lane addr[1].
  assign rd_byte = mem_q[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half = mem_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = mem_q;
    case (size_q)
      SZ_BYTE: load_ext = signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      SZ_HALF: load_ext = signed_q ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
      default: load_ext = mem_q;
    endcase
  end

  always_comb begin
    merged = mem_q;
    if (size_q == SZ_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (size_q == SZ_HALF) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    mdata_d  = mdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_err;
          if (req_err) begin
            rdata_d = '0;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!write_q) begin
          rdata_d = load_ext;
          state_d = RESP;
        end else begin
          rdata_d = '0;
          if (size_q == SZ_WORD) begin
            state_d = RESP;
          end else begin
            mdata_d = merged;
            state_d = WRITE;
          end
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      mdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      mdata_q  <= mdata_d;
    end
  end

  // RESET gates req_ready directly so it is low for the whole reset window.
  assign req_ready   = RESET && (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_err    = resp_valid && err_q;
  assign resp_rdata  = rdata_q;
  assign mem_address = addr_q[ADDR_W+1:2];
  // A word store writes straight from the latched data. A sub-word store
  // writes the merged word that was registered in ACCESS.
  assign mem_we      = ((state_q == ACCESS) && word_store) || (state_q == WRITE);
  assign mem_data    = ((state_q == ACCESS) && word_store) ? wdata_q : mdata_q;

endmodule

// File: tb/tb_dm_access_master.sv
module tb_dm_access_master;

  logic        CLK;
  logic        RESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_we;
  logic [31:0] mem_q;

  logic [31:0] mem [1024];

  int n_checks = 0;
  int n_errors = 0;

  dm_access_master #(.ADDR_W(10), .DATA_W(32)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_we      (mem_we),
    .mem_q       (mem_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign mem_q = mem[mem_address];
  always @(posedge CLK) begin
    if (mem_we) mem[mem_address] <= mem_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it to its response.
  // exp_we = 1 means exactly one write cycle is expected, in the cycle just
  // before the response, carrying exp_md.
  task automatic do_op(input string tag, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [11:0] a, input logic [31:0] wd,
                       input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                       input int exp_we, input logic [31:0] exp_md);
    int lat;
    int we_cnt;
    int we_cyc;
    logic [31:0] we_data;
    logic [9:0]  we_addr;
    lat = 0; we_cnt = 0; we_cyc = 0; we_data = '0; we_addr = '0;
    @(negedge CLK);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    #1 chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge CLK);
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      req_valid = 1'b0;
      // Scramble the inputs to show the latched fields are held.
      req_wdata = 32'h5A5A5A5A; req_addr = 12'hFFF; req_size = 2'b11;
      if (mem_we) begin
        we_cnt++; we_cyc = c; we_data = mem_data; we_addr = mem_address;
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    chk({tag, ".we_count"}, we_cnt, exp_we);
    if (exp_we != 0) begin
      chk({tag, ".we_cycle"}, we_cyc, exp_lat - 1);
      chk({tag, ".we_data"}, we_data, exp_md);
      chk({tag, ".we_addr"}, {22'd0, we_addr}, {22'd0, a[11:2]});
    end
  endtask

  int rv_cnt;
  int idx;
  int acc_cyc [3];
  logic [31:0] b2b_data [3];

  initial begin
    RESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge CLK);
    chk("rst.ready", {31'd0, req_ready}, 32'd0);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst.mem_addr", {22'd0, mem_address}, 32'd0);
    chk("rst.mem_data", mem_data, 32'd0);
    RESET = 1'b1;

    do_op("wst", 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1, 32'hDEADBEEF);
    chk("wst.mem4", mem[4], 32'hDEADBEEF);
    do_op("lb_s", 1'b0, 2'b00, 1'b1, 12'h013, 32'h0, 2, 1'b0, 32'hFFFFFFDE, 0, 32'h0);
    do_op("lb_u", 1'b0, 2'b00, 1'b0, 12'h013, 32'h0, 2, 1'b0, 32'h000000DE, 0, 32'h0);
    do_op("lh_s", 1'b0, 2'b01, 1'b1, 12'h010, 32'h0, 2, 1'b0, 32'hFFFFBEEF, 0, 32'h0);
    do_op("lh_u", 1'b0, 2'b01, 1'b0, 12'h012, 32'h0, 2, 1'b0, 32'h0000DEAD, 0, 32'h0);
    do_op("lw", 1'b0, 2'b10, 1'b1, 12'h010, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0, 32'h0);
    do_op("sh", 1'b1, 2'b01, 1'b0, 12'h012, 32'hFFFF1234, 3, 1'b0, 32'h0, 1, 32'h1234BEEF);
    chk("sh.mem4", mem[4], 32'h1234BEEF);
    do_op("sb", 1'b1, 2'b00, 1'b0, 12'h011, 32'hFFFFFFAA, 3, 1'b0, 32'h0, 1, 32'h1234AAEF);
    chk("sb.mem4", mem[4], 32'h1234AAEF);

    // Load first, so a following error has to clear resp_rdata.
    do_op("wst0", 1'b1, 2'b10, 1'b0, 12'h000, 32'h00000055, 2, 1'b0, 32'h0, 1, 32'h00000055);
    do_op("lw4", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 2, 1'b0, 32'h1234AAEF, 0, 32'h0);
    do_op("err_lw", 1'b0, 2'b10, 1'b0, 12'h006, 32'h0, 1, 1'b1, 32'h0, 0, 32'h0);
    do_op("err_sh", 1'b1, 2'b01, 1'b0, 12'h011, 32'h0000FFFF, 1, 1'b1, 32'h0, 0, 32'h0);
    do_op("err_sz", 1'b1, 2'b11, 1'b0, 12'h000, 32'hFFFFFFFF, 1, 1'b1, 32'h0, 0, 32'h0);
    chk("err.mem4", mem[4], 32'h1234AAEF);
    chk("err.mem0", mem[0], 32'h00000055);

    // Reset during the write-back of a byte store.
    do_op("wst5", 1'b1, 2'b10, 1'b0, 12'h014, 32'h11223344, 2, 1'b0, 32'h0, 1, 32'h11223344);
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 12'h014;
    req_wdata = 32'h00000099;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("rstw.access_we", {31'd0, mem_we}, 32'd0);
    @(negedge CLK);
    chk("rstw.write_we", {31'd0, mem_we}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("rstw.we_drop", {31'd0, mem_we}, 32'd0);
    chk("rstw.ready_low", {31'd0, req_ready}, 32'd0);
    rv_cnt = 0;
    @(negedge CLK);
    if (resp_valid) rv_cnt++;
    chk("rstw.mem5", mem[5], 32'h11223344);
    chk("rstw.ready_held", {31'd0, req_ready}, 32'd0);
    RESET = 1'b1;
    #1 chk("rstw.ready_rel", {31'd0, req_ready}, 32'd1);
    repeat (4) begin
      @(negedge CLK);
      if (resp_valid) rv_cnt++;
    end
    chk("rstw.no_resp", rv_cnt, 0);
    chk("rstw.mem5_after", mem[5], 32'h11223344);

    // Back-to-back word stores with req_valid held high.
    b2b_data[0] = 32'hA0A0A0A0; b2b_data[1] = 32'hB1B1B1B1; b2b_data[2] = 32'hC2C2C2C2;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (idx < 3) begin
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        req_addr = 12'h100 + 12'(4 * idx); req_wdata = b2b_data[idx];
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (c < 9) chk($sformatf("b2b.ready%0d", c), {31'd0, req_ready}, {31'd0, c % 3 == 0});
      if (req_valid && req_ready) begin
        acc_cyc[idx] = c;
        idx++;
      end
    end
    chk("b2b.accepts", idx, 3);
    chk("b2b.gap1", acc_cyc[1] - acc_cyc[0], 3);
    chk("b2b.gap2", acc_cyc[2] - acc_cyc[1], 3);
    chk("b2b.mem64", mem[64], 32'hA0A0A0A0);
    chk("b2b.mem65", mem[65], 32'hB1B1B1B1);
    chk("b2b.mem66", mem[66], 32'hC2C2C2C2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_access_master.md
Name: dm_access_master

Overview:
- Processor-side initiator for the word-addressed data memory: 1024 x 32, combinational read, write on posedge CLK when WE.
- Accepts byte, halfword and word load/store requests on byte addresses through a valid/ready handshake.
- Maps each request onto word accesses and performs read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
ADDR_W, 10, memory word-address width; byte address is ADDR_W+2 bits
DATA_W, 32, memory word width; fixed at 32 (byte-lane logic assumes 4 lanes)

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready on a CLK edge
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  12  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid: misaligned or illegal size
resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors
mem_address  out  10  to memory ADDRESS
mem_data  out  32  to memory DATA
mem_we  out  1  to memory WE
mem_q  in  32  from memory Q (combinational read of mem_address)

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP.
- Reset (RESET low, asynchronous): state=IDLE. req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_address=0, mem_data=0. All latched request fields are 0.
- req_ready=1 only in IDLE with RESET high; combinational from state.
- IDLE, on accept: latch write, size, signed, addr, wdata.
  - Error when size==11, or size==01 with addr[0]!=0, or size==10 with addr[1:0]!=0.
  - Error -> RESP with err=1; the memory is never written for an errored request.
  - Otherwise -> ACCESS.
- mem_address = latched addr[11:2] in every state except reset.
- Byte lanes are little-endian: lane k = bits 8k+7:8k, selected by addr[1:0]. A halfword occupies lanes addr[1]*2 and addr[1]*2+1.
- ACCESS, load: extract the lane(s) from mem_q, extend per signed, register into resp_rdata, go to RESP.
- ACCESS, word store: mem_we=1, mem_data=wdata, go to RESP. The write takes effect on that edge.
- ACCESS, sub-word store: merge wdata into the mem_q word at the selected lane(s), register into mem_data, go to WRITE. mem_we=0 in ACCESS.
- WRITE: mem_we=1 with the merged mem_data for exactly one cycle, then RESP.
- RESP: resp_valid=1 for exactly one cycle, resp_err as latched, then IDLE. resp_rdata holds its value until the next response; it is 0 for stores and errors.
- mem_we is never high outside ACCESS (word store) or WRITE, and never high for two consecutive cycles.
- Latency in cycles after the accept edge, counting to resp_valid high:
  - error: 1
  - load or word store: 2
  - sub-word store: 3
- Throughput: the next request can be accepted in the cycle after RESP. Minimum spacing is 3 cycles for word operations and 4 for sub-word stores.
- Request inputs are ignored outside IDLE. Latched fields are immune to input changes mid-operation.
- Reset mid-operation:
  - mem_we drops immediately (asynchronous).
  - Reset asserted before the WRITE edge leaves the memory unmodified.
  - No resp_valid is generated for the aborted request.
- Read-modify-write is not atomic against other memory writers; this block is the sole writer.

Test Plan:
- Word store 0xDEADBEEF at addr 0x010 -> mem_we high exactly 1 cycle with mem_address=4; memory word 4=0xDEADBEEF; resp_valid 2 cycles after accept, resp_err=0, resp_rdata=0.
- With word 4=0xDEADBEEF, byte load addr 0x013 -> signed gives resp_rdata=0xFFFFFFDE, unsigned gives 0x000000DE. Halfword signed load addr 0x010 -> 0xFFFFBEEF. Never mem_we.
- Halfword store 0x1234 at addr 0x012 over 0xDEADBEEF -> mem_we low in ACCESS, high 1 cycle in WRITE with mem_data=0x1234BEEF; resp_valid 3 cycles after accept. Byte store 0xAA at 0x011 then gives 0x1234AAEF.
- Misaligned word load at 0x006, halfword store at 0x011, and size=11 -> each gives resp_valid 1 cycle after accept with resp_err=1, resp_rdata=0, and mem_we never asserted.
- Reset low during WRITE of a byte store to a word holding 0x11223344 -> mem_we falls immediately; word still 0x11223344; no resp_valid; req_ready=0 while reset is low, 1 on the first cycle after release.
- Back-to-back: req_valid held high with 3 queued word stores -> exactly one accept per 3 cycles; req_ready low in ACCESS and RESP; all 3 words written in order.
